mc_ctrl: RTL and testbench

Multi-cycle sequencer for the miniRV datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and generates the per-state enables: PC update, IR load, register-file write, and data-memory request/write. It sits beside the decode stage and gates the decoder's static rf_wen/dram_wen so each takes effect in exactly one cycle. It includes a memory-wait timeout watchdog and illegal-opcode trapping.

---
 rtl/mc_pkg.sv | 35 +++
 rtl/mc_timeout.sv | 30 +++
 rtl/mc_ctrl.sv | 148 ++++++++++++++
 tb/tb_mc_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the miniRV multi-cycle sequencer:
// state encodings, opcode constants and the legal-opcode check.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // True for every opcode the datapath implements; anything else traps.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_timeout.sv
// Memory-wait watchdog: counts cycles spent waiting on a ready signal and
// flags expiry on the last allowed waiting cycle (count == TO_CYCLES-1).
module mc_timeout #(
  parameter int TO_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Wait counter: cleared on reset or on entry to a waiting state, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Expired only when still waiting on the limit cycle, so a late ready wins.
  assign expired = inc && (cnt_reg == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer for the miniRV datapath (FETCH/DECODE/EXEC/MEM/WB/ERR).
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int TO_CYCLES = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             dec_rf_wen,
  input  logic             dec_dram_wen,
  input  logic             imem_ready,
  input  logic             dram_ready,
  output logic             imem_req,
  output logic             ir_wen,
  output logic             pc_wen,
  output logic             rf_wen,
  output logic             dram_req,
  output logic             dram_wen,
  output logic             instr_done,
  output logic             err,
  output logic [2:0]       state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       to_clear;
  logic       to_inc;
  logic       to_expired;
  logic       is_mem_op;
  logic       is_store;

  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_store  = (opcode == OP_STORE);

  // The watchdog only counts while FETCH or MEM is stalled on its ready.
  assign to_inc   = ((state_reg == S_FETCH) && !imem_ready) ||
                    ((state_reg == S_MEM)   && !dram_ready);
  assign to_clear = (state_next != state_reg) &&
                    ((state_next == S_FETCH) || (state_next == S_MEM));

  mc_timeout #(
    .TO_CYCLES(TO_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .inc    (to_inc),
    .expired(to_expired)
  );

  // State register; reset always restarts at FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; unused encodings fall into ERR.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (imem_ready)      state_next = S_DECODE;
        else if (to_expired) state_next = S_ERR;
      end
      S_DECODE: state_next = is_legal_op(opcode) ? S_EXEC : S_ERR;
      S_EXEC: begin
        if (is_mem_op)       state_next = S_MEM;
        else if (dec_rf_wen) state_next = S_WB;
        else                 state_next = S_FETCH;
      end
      S_MEM: begin
        if (dram_ready)      state_next = is_store ? S_FETCH : S_WB;
        else if (to_expired) state_next = S_ERR;
      end
      S_WB:    state_next = S_FETCH;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Output decode from state and ready inputs; everything held at 0 during reset.
  always_comb begin
    imem_req   = 1'b0;
    ir_wen     = 1'b0;
    pc_wen     = 1'b0;
    rf_wen     = 1'b0;
    dram_req   = 1'b0;
    dram_wen   = 1'b0;
    instr_done = 1'b0;
    err        = 1'b0;
    state      = 3'd0;
    if (!rst) begin
      state = state_reg;
      case (state_reg)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wen   = imem_ready;
        end
        S_EXEC: begin
          if (!is_mem_op && !dec_rf_wen) begin
            pc_wen     = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          dram_req = 1'b1;
          dram_wen = dec_dram_wen;
          if (dram_ready && is_store) begin
            pc_wen     = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          rf_wen     = dec_rf_wen;
          pc_wen     = 1'b1;
          instr_done = 1'b1;
        end
        S_DECODE: ;
        default: err = 1'b1;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  // Cycle and retired-instruction counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (default TO_CYCLES=16).
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       dec_rf_wen;
  logic       dec_dram_wen;
  logic       imem_ready;
  logic       dram_ready;
  logic       imem_req, ir_wen, pc_wen, rf_wen, dram_req, dram_wen, instr_done, err;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Output vector order: {imem_req, ir_wen, pc_wen, rf_wen, dram_req, dram_wen, instr_done, err}
  localparam logic [7:0] V_IDLE   = 8'b0000_0000;
  localparam logic [7:0] V_FWAIT  = 8'b1000_0000;
  localparam logic [7:0] V_FETCH  = 8'b1100_0000;
  localparam logic [7:0] V_WB     = 8'b0011_0010;
  localparam logic [7:0] V_WB_NRF = 8'b0010_0010;
  localparam logic [7:0] V_MEM_LD = 8'b0000_1000;
  localparam logic [7:0] V_MEM_ST = 8'b0010_1110;
  localparam logic [7:0] V_BRANCH = 8'b0010_0010;
  localparam logic [7:0] V_ERR    = 8'b0000_0001;

  mc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .dec_rf_wen  (dec_rf_wen),
    .dec_dram_wen(dec_dram_wen),
    .imem_ready  (imem_ready),
    .dram_ready  (dram_ready),
    .imem_req    (imem_req),
    .ir_wen      (ir_wen),
    .pc_wen      (pc_wen),
    .rf_wen      (rf_wen),
    .dram_req    (dram_req),
    .dram_wen    (dram_wen),
    .instr_done  (instr_done),
    .err         (err),
    .state       (state)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Check state and outputs for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] exp_st, input logic [7:0] exp_v);
    logic [7:0] obs_v;
    #1;
    obs_v = {imem_req, ir_wen, pc_wen, rf_wen, dram_req, dram_wen, instr_done, err};
    checks++;
    assert (state === exp_st) else begin
      failures++;
      $error("FAIL %s state: observed=%0d expected=%0d", tag, state, exp_st);
    end
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s outputs: observed=%b expected=%b", tag, obs_v, exp_v);
    end
    $display("cycle %s state=%0d outs=%b", tag, state, obs_v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'b0110011; dec_rf_wen = 1'b1; dec_dram_wen = 1'b0;
    imem_ready = 1'b1; dram_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset_hold", 3'd0, V_IDLE);
    rst = 1'b0;

    // R-type: 4 cycles, writes only in WB
    cyc("rtype_fetch",  3'd0, V_FETCH);
    cyc("rtype_decode", 3'd1, V_IDLE);
    cyc("rtype_exec",   3'd2, V_IDLE);
    cyc("rtype_wb",     3'd4, V_WB);

    // Load with dram_ready late by 3 cycles: 8 cycles total
    opcode = 7'b0000011; dec_rf_wen = 1'b1; dram_ready = 1'b0;
    cyc("load_fetch",  3'd0, V_FETCH);
    cyc("load_decode", 3'd1, V_IDLE);
    cyc("load_exec",   3'd2, V_IDLE);
    cyc("load_mem_w0", 3'd3, V_MEM_LD);
    cyc("load_mem_w1", 3'd3, V_MEM_LD);
    cyc("load_mem_w2", 3'd3, V_MEM_LD);
    dram_ready = 1'b1;
    cyc("load_mem_rdy", 3'd3, V_MEM_LD);
    cyc("load_wb",      3'd4, V_WB);

    // Store, zero-wait: pc_wen in MEM, no rf_wen
    opcode = 7'b0100011; dec_rf_wen = 1'b0; dec_dram_wen = 1'b1;
    cyc("store_fetch",  3'd0, V_FETCH);
    cyc("store_decode", 3'd1, V_IDLE);
    cyc("store_exec",   3'd2, V_IDLE);
    cyc("store_mem",    3'd3, V_MEM_ST);
    dec_dram_wen = 1'b0;

    // Branch: retires in EXEC, 3 cycles
    opcode = 7'b1100011; dec_rf_wen = 1'b0;
    cyc("br_fetch",  3'd0, V_FETCH);
    cyc("br_decode", 3'd1, V_IDLE);
    cyc("br_exec",   3'd2, V_BRANCH);

    // JAL: 4 cycles via WB; then a WB with dec_rf_wen low leaves rf_wen off
    opcode = 7'b1101111; dec_rf_wen = 1'b1;
    cyc("jal_fetch",  3'd0, V_FETCH);
    cyc("jal_decode", 3'd1, V_IDLE);
    cyc("jal_exec",   3'd2, V_IDLE);
    dec_rf_wen = 1'b0;
    cyc("jal_wb_norf", 3'd4, V_WB_NRF);

    // Reset while in WB: no enables on the reset cycle
    opcode = 7'b0010011; dec_rf_wen = 1'b1;
    cyc("imm_fetch",  3'd0, V_FETCH);
    cyc("imm_decode", 3'd1, V_IDLE);
    cyc("imm_exec",   3'd2, V_IDLE);
    rst = 1'b1;
    cyc("imm_wb_rst", 3'd0, V_IDLE);
    rst = 1'b0;
    cyc("after_rst_fetch", 3'd0, V_FETCH);

    // Illegal opcode traps, ERR sticky for 20 cycles, cleared by rst
    opcode = 7'b1111111;
    cyc("ill_decode", 3'd1, V_IDLE);
    for (int i = 0; i < 20; i++) cyc($sformatf("ill_err%0d", i), 3'd5, V_ERR);
    rst = 1'b1;
    cyc("ill_rst", 3'd0, V_IDLE);
    rst = 1'b0;
    opcode = 7'b0110011;
    cyc("ill_after_rst", 3'd0, V_FETCH);

    // Fetch timeout: 16 waiting FETCH cycles then ERR
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    imem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("fto_wait%0d", i), 3'd0, V_FWAIT);
    cyc("fto_err", 3'd5, V_ERR);

    // Ready on the limit cycle wins over the timeout
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("flim_wait%0d", i), 3'd0, V_FWAIT);
    imem_ready = 1'b1;
    cyc("flim_ready", 3'd0, V_FETCH);
    cyc("flim_decode", 3'd1, V_IDLE);

    // Data-memory timeout on a load: 16 MEM cycles then ERR
    opcode = 7'b0000011; dram_ready = 1'b0;
    cyc("mto_exec", 3'd2, V_IDLE);
    for (int i = 0; i < 16; i++) cyc($sformatf("mto_wait%0d", i), 3'd3, V_MEM_LD);
    cyc("mto_err", 3'd5, V_ERR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
